// File: rtl/alu_serial_ctrl.sv
// -----------------------------------------------------------------------------
// alu_serial_ctrl
//   Bit-serial sequencer for a 1-bit ALU slice. An accepted start captures two
//   N-bit operands and an opcode. The controller then drives the slice LSB-first
//   for N cycles. The slice has no carry-in, so carry/borrow propagation is done
//   here. The result is assembled by shifting each bit in from the MSB side, and
//   a final carry/borrow is registered with it.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   start             : request, accepted whenever busy=0 (IDLE or DONE)
//   op[2:0]           : 000 AND, 001 OR, 010 ADD, 011 SUB, 100 LESS, 101-111 ADD
//   a_in, b_in [N-1:0]: operands, captured on an accepted start
//   alu_sel/a/b       : registered drive to the slice
//   alu_dout/alu_cout : slice outputs (combinational from alu_sel/a/b)
//   busy              : high while the serial run is in progress
//   done              : one-cycle pulse when result/carry_out are valid
//   result[N-1:0]     : result, held until the next accepted start
//   carry_out         : final carry (ADD) or borrow (SUB), else 0
// -----------------------------------------------------------------------------
module alu_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic [2:0]   alu_sel,
  output logic         alu_a,
  output logic         alu_b,
  input  logic         alu_dout,
  input  logic         alu_cout,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         carry_out
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LESS = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [2:0]     op_q;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [CW-1:0]  cnt;
  logic           c;

  logic           rbit;
  logic           c_next;
  logic [2:0]     op_cap;
  logic           accept;

  // Reserved encodings fall back to ADD.
  function automatic logic [2:0] remap_op(input logic [2:0] o);
    return (o > OP_LESS) ? OP_ADD : o;
  endfunction

  // LESS is evaluated as a subtraction whose final borrow is the answer.
  function automatic logic [2:0] slice_sel(input logic [2:0] o);
    return (o == OP_LESS) ? OP_SUB : o;
  endfunction

  // The operand shift registers present bit k at position 0 in RUN cycle k.
  // They drain to zero by the end of the run, which gives alu_a/alu_b = 0
  // in IDLE/DONE without extra gating.
  assign alu_a  = a_sh[0];
  assign alu_b  = b_sh[0];

  assign op_cap = remap_op(op);
  assign accept = (state != RUN) && start;

  // Fold the external carry/borrow into the slice's per-bit answer.
  always_comb begin
    rbit   = alu_dout;
    c_next = 1'b0;
    case (op_q)
      OP_ADD: begin
        rbit   = alu_dout ^ c;
        c_next = alu_cout | (alu_dout & c);
      end
      OP_SUB, OP_LESS: begin
        rbit   = alu_dout ^ c;
        c_next = alu_cout | (~alu_dout & c);
      end
      default: begin
        rbit   = alu_dout;
        c_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_AND;
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      c         <= 1'b0;
      alu_sel   <= OP_AND;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done    <= 1'b0;
          alu_sel <= OP_AND;
          state   <= IDLE;
          if (accept) begin
            op_q      <= op_cap;
            a_sh      <= a_in;
            b_sh      <= b_in;
            cnt       <= '0;
            c         <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            alu_sel   <= slice_sel(op_cap);
            busy      <= 1'b1;
            state     <= RUN;
          end
        end

        RUN: begin
          result <= {rbit, result[N-1:1]};
          c      <= c_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            alu_sel   <= OP_AND;
            cnt       <= '0;
            carry_out <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? c_next : 1'b0;
            if (op_q == OP_LESS) begin
              result <= {{(N-1){1'b0}}, c_next};
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
